// File: rtl/avs_reg_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM register slave between NUM_REQ masters.
// Optional stall timeout on the slave port is built when ARB_TIMEOUT_EN is defined.
module avs_reg_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      csi_clockreset_clk,
    input  logic                      csi_clockreset_reset,
    input  logic [NUM_REQ*ADDR_W-1:0] avs_req_address,
    input  logic [NUM_REQ*DATA_W-1:0] avs_req_writedata,
    input  logic [NUM_REQ-1:0]        avs_req_write_n,
    input  logic [NUM_REQ-1:0]        avs_req_read_n,
    output logic [DATA_W-1:0]         avs_req_readdata,
    output logic [NUM_REQ-1:0]        avs_req_waitrequest_n,
    output logic [ADDR_W-1:0]         avm_address,
    output logic [DATA_W-1:0]         avm_writedata,
    output logic                      avm_write_n,
    output logic                      avm_read_n,
    input  logic [DATA_W-1:0]         avm_readdata,
    input  logic                      avm_waitrequest_n,
    output logic [NUM_REQ-1:0]        arb_grant,
    output logic                      arb_error
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_n_q, write_n_d;
    logic                read_n_q, read_n_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                err_q, err_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
    logic [StallW-1:0]   stall_q, stall_d;
`endif

    logic [NUM_REQ-1:0]  pending;
    logic                hi_valid, lo_valid, pick_valid;
    logic [IdxW-1:0]     hi_idx, lo_idx, pick_idx;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wdata;
    logic                pick_write;

    assign pending = ~avs_req_write_n | ~avs_req_read_n;

    // Lowest pending index above last grant wins; otherwise wrap to the lowest pending index.
    always_comb begin
        hi_valid = 1'b0;
        lo_valid = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (IdxW'(i) > last_q) begin
                    hi_valid = 1'b1;
                    hi_idx   = IdxW'(i);
                end else begin
                    lo_valid = 1'b1;
                    lo_idx   = IdxW'(i);
                end
            end
        end
        pick_valid = hi_valid | lo_valid;
        pick_idx   = hi_valid ? hi_idx : lo_idx;
    end

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IdxW'(i) == pick_idx) begin
                pick_addr  = avs_req_address[i*ADDR_W +: ADDR_W];
                pick_wdata = avs_req_writedata[i*DATA_W +: DATA_W];
                pick_write = ~avs_req_write_n[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_n_d = write_n_q;
        read_n_d  = read_n_q;
        rdata_d   = rdata_q;
        ack_d     = '0;
        err_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        stall_d   = stall_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d   = StIssue;
                    grant_d   = NUM_REQ'(1) << pick_idx;
                    last_d    = pick_idx;
                    addr_d    = pick_addr;
                    wdata_d   = pick_wdata;
                    // Write has precedence when both strobes are low.
                    write_n_d = ~pick_write;
                    read_n_d  = pick_write;
`ifdef ARB_TIMEOUT_EN
                    stall_d   = '0;
`endif
                end
            end
            StIssue: begin
                if (avm_waitrequest_n) begin
                    if (!read_n_q) begin
                        rdata_d = avm_readdata;
                    end
                    write_n_d = 1'b1;
                    read_n_d  = 1'b1;
                    ack_d     = grant_q;
                    state_d   = StDone;
                end
`ifdef ARB_TIMEOUT_EN
                else if (stall_q == StallW'(TIMEOUT_CYCLES - 1)) begin
                    if (!read_n_q) begin
                        rdata_d = DATA_W'(8'hEE);
                    end
                    write_n_d = 1'b1;
                    read_n_d  = 1'b1;
                    ack_d     = grant_q;
                    err_d     = 1'b1;
                    state_d   = StDone;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            StDone: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= IdxW'(NUM_REQ - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            write_n_q <= 1'b1;
            read_n_q  <= 1'b1;
            rdata_q   <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_n_q <= write_n_d;
            read_n_q  <= read_n_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    assign avs_req_readdata      = rdata_q;
    assign avs_req_waitrequest_n = ack_q;
    assign avm_address           = addr_q;
    assign avm_writedata         = wdata_q;
    assign avm_write_n           = write_n_q;
    assign avm_read_n            = read_n_q;
    assign arb_grant             = grant_q;
    assign arb_error             = err_q;

endmodule

// File: tb/tb_avs_reg_arbiter.sv
// Scoreboard bench for avs_reg_arbiter with a configurable-stall slave model.
module tb_avs_reg_arbiter;
    localparam int NR = 2;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct {
        int         req;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] req_addr    = '0;
    logic [NR*DW-1:0] req_wdata   = '0;
    logic [NR-1:0]    req_write_n = '1;
    logic [NR-1:0]    req_read_n  = '1;
    logic [DW-1:0]    req_rdata;
    logic [NR-1:0]    req_waitreq_n;
    logic [AW-1:0]    avm_address;
    logic [DW-1:0]    avm_writedata;
    logic             avm_write_n, avm_read_n;
    logic [DW-1:0]    avm_readdata      = '0;
    logic             avm_waitrequest_n = 1'b0;
    logic [NR-1:0]    arb_grant;
    logic             arb_error;

    avs_reg_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .csi_clockreset_clk   (clk),
        .csi_clockreset_reset (rst),
        .avs_req_address      (req_addr),
        .avs_req_writedata    (req_wdata),
        .avs_req_write_n      (req_write_n),
        .avs_req_read_n       (req_read_n),
        .avs_req_readdata     (req_rdata),
        .avs_req_waitrequest_n(req_waitreq_n),
        .avm_address          (avm_address),
        .avm_writedata        (avm_writedata),
        .avm_write_n          (avm_write_n),
        .avm_read_n           (avm_read_n),
        .avm_readdata         (avm_readdata),
        .avm_waitrequest_n    (avm_waitrequest_n),
        .arb_grant            (arb_grant),
        .arb_error            (arb_error)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         slave_stall = 0;  // negative: never ready
    int         slave_cnt = 0;
    logic       in_txn = 1'b0;
    logic [7:0] model_rdata = 8'h00;
    exp_t       sb[$];

    // Observations of one transaction collected by wait_ack
    int         o_cyc, o_strobe, o_err;
    logic [1:0] o_ack, o_grant;
    logic [3:0] o_addr;
    logic [7:0] o_data, o_rdata;
    logic       o_wr, o_rd, o_stable, o_err_at_ack;
    exp_t       e;

    task automatic update_slave();
        if (!avm_write_n || !avm_read_n) begin
            if (in_txn) slave_cnt++;
            else begin in_txn = 1'b1; slave_cnt = 0; end
            avm_waitrequest_n = (slave_stall >= 0) && (slave_cnt >= slave_stall);
        end else begin
            in_txn = 1'b0;
            avm_waitrequest_n = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        update_slave();
    endtask

    task automatic wait_ack(input int max_cyc);
        logic [13:0] prev, cur;
        logic seen;
        seen = 1'b0; prev = '0;
        o_cyc = 0; o_strobe = 0; o_err = 0; o_ack = '0; o_grant = '0; o_addr = '0;
        o_data = '0; o_rdata = '0; o_wr = 1'b0; o_rd = 1'b0; o_stable = 1'b1; o_err_at_ack = 1'b0;
        while (o_cyc < max_cyc) begin
            step();
            o_cyc++;
            if (arb_error) o_err++;
            if (!avm_write_n || !avm_read_n) begin
                cur = {avm_address, avm_writedata, avm_write_n, avm_read_n};
                if (seen && cur != prev) o_stable = 1'b0;
                prev = cur; seen = 1'b1; o_strobe++;
                o_addr = avm_address; o_data = avm_writedata; o_grant = arb_grant;
                if (!avm_write_n) o_wr = 1'b1;
                if (!avm_read_n) o_rd = 1'b1;
            end
            if (req_waitreq_n != '0) begin
                o_ack = req_waitreq_n; o_rdata = req_rdata; o_err_at_ack = arb_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++; if (avm_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_write_n: got %b want 1", avm_write_n); end
        n_checks++; if (avm_read_n !== 1'b1) begin n_fail++; $display("FAIL reset_read_n: got %b want 1", avm_read_n); end
        n_checks++; if (avm_address !== 4'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0", avm_address); end
        n_checks++; if (avm_writedata !== 8'h00) begin n_fail++; $display("FAIL reset_writedata: got %h want 00", avm_writedata); end
        n_checks++; if (req_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_readdata: got %h want 00", req_rdata); end
        n_checks++; if (req_waitreq_n !== 2'b00) begin n_fail++; $display("FAIL reset_waitreq: got %b want 00", req_waitreq_n); end
        n_checks++; if (arb_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", arb_grant); end
        n_checks++; if (arb_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", arb_error); end
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        slave_stall = 0;
        req_addr[3:0] = 4'h3; req_wdata[7:0] = 8'h5A; req_write_n[0] = 1'b0;
        sb.push_back('{0, 1'b1, 4'h3, 8'h5A, model_rdata, 2});
        wait_ack(10);
        req_write_n[0] = 1'b1;
        e = sb.pop_front();
        n_checks++; if (o_ack !== 2'(1 << e.req)) begin n_fail++; $display("FAIL wr_ack: got %b want req %0d", o_ack, e.req); end
        n_checks++; if (o_cyc !== e.lat) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", o_cyc, e.lat); end
        n_checks++; if (o_strobe !== 1) begin n_fail++; $display("FAIL wr_strobe_len: got %0d want 1", o_strobe); end
        n_checks++; if ({o_wr, o_rd} !== 2'b10) begin n_fail++; $display("FAIL wr_dir: got %b want 10", {o_wr, o_rd}); end
        n_checks++; if ({o_addr, o_data} !== {e.addr, e.data}) begin n_fail++; $display("FAIL wr_issue: got %h/%h want %h/%h", o_addr, o_data, e.addr, e.data); end
        n_checks++; if (o_grant !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b want 01", o_grant); end
        n_checks++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want %h", o_rdata, e.rdata); end
        step();
        n_checks++; if ({req_waitreq_n, arb_grant} !== 4'b0000) begin n_fail++; $display("FAIL wr_ack_one_cycle: got %b/%b want 00/00", req_waitreq_n, arb_grant); end
    endtask

    task automatic test_read_stall();
        slave_stall = 3; avm_readdata = 8'hC3;
        req_addr[7:4] = 4'h2; req_read_n[1] = 1'b0;
        model_rdata = 8'hC3;
        sb.push_back('{1, 1'b0, 4'h2, 8'h00, 8'hC3, 5});
        wait_ack(20);
        req_read_n[1] = 1'b1;
        e = sb.pop_front();
        n_checks++; if (o_ack !== 2'(1 << e.req)) begin n_fail++; $display("FAIL rd_ack: got %b want req %0d", o_ack, e.req); end
        n_checks++; if (o_cyc !== e.lat) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", o_cyc, e.lat); end
        n_checks++; if (o_strobe !== 4 || o_stable !== 1'b1) begin n_fail++; $display("FAIL rd_strobe_held: got %0d stable %b want 4 stable 1", o_strobe, o_stable); end
        n_checks++; if ({o_wr, o_rd, o_addr} !== {2'b01, e.addr}) begin n_fail++; $display("FAIL rd_issue: got %b%b/%h want 01/%h", o_wr, o_rd, o_addr, e.addr); end
        n_checks++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL rd_data: got %h want %h", o_rdata, e.rdata); end
        step();
    endtask

    task automatic test_round_robin();
        slave_stall = 0;
        req_addr = {4'h2, 4'h1}; req_wdata = {8'h21, 8'h10}; req_write_n = 2'b00;
        sb.push_back('{0, 1'b1, 4'h1, 8'h10, model_rdata, 2});
        sb.push_back('{1, 1'b1, 4'h2, 8'h21, model_rdata, 3});
        sb.push_back('{0, 1'b1, 4'h1, 8'h12, model_rdata, 3});
        sb.push_back('{1, 1'b1, 4'h2, 8'h23, model_rdata, 3});
        for (int k = 0; k < 4; k++) begin
            wait_ack(10);
            case (k)
                0: req_wdata[7:0] = 8'h12;
                1: req_wdata[15:8] = 8'h23;
                2: req_write_n[0] = 1'b1;
                default: req_write_n[1] = 1'b1;
            endcase
            e = sb.pop_front();
            n_checks++; if (o_ack !== 2'(1 << e.req) || o_grant !== o_ack) begin n_fail++; $display("FAIL rr_order[%0d]: ack %b grant %b want req %0d", k, o_ack, o_grant, e.req); end
            n_checks++; if (o_cyc !== e.lat) begin n_fail++; $display("FAIL rr_latency[%0d]: got %0d want %0d", k, o_cyc, e.lat); end
            n_checks++; if ({o_addr, o_data} !== {e.addr, e.data}) begin n_fail++; $display("FAIL rr_issue[%0d]: got %h/%h want %h/%h", k, o_addr, o_data, e.addr, e.data); end
        end
        step();
    endtask

    task automatic test_write_and_read();
        req_addr[3:0] = 4'h5; req_wdata[7:0] = 8'h11; req_write_n[0] = 1'b0; req_read_n[0] = 1'b0;
        sb.push_back('{0, 1'b1, 4'h5, 8'h11, model_rdata, 2});
        wait_ack(10);
        req_write_n[0] = 1'b1; req_read_n[0] = 1'b1;
        e = sb.pop_front();
        n_checks++; if (o_ack !== 2'(1 << e.req)) begin n_fail++; $display("FAIL both_ack: got %b want req %0d", o_ack, e.req); end
        n_checks++; if ({o_wr, o_rd} !== 2'b10) begin n_fail++; $display("FAIL both_write_only: got %b want 10", {o_wr, o_rd}); end
        n_checks++; if ({o_addr, o_data} !== {e.addr, e.data}) begin n_fail++; $display("FAIL both_issue: got %h/%h want %h/%h", o_addr, o_data, e.addr, e.data); end
        n_checks++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL both_rdata_kept: got %h want %h", o_rdata, e.rdata); end
        step();
    endtask

    task automatic test_reset_mid_issue();
        slave_stall = -1;
        req_addr = {4'h6, 4'h4}; req_wdata[15:8] = 8'h66; req_read_n[0] = 1'b0;
        step();
        n_checks++; if ({avm_read_n, arb_grant} !== 3'b001) begin n_fail++; $display("FAIL mid_issue_active: got %b/%b want 0/01", avm_read_n, arb_grant); end
        req_write_n[1] = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({avm_write_n, avm_read_n, arb_grant, req_waitreq_n} !== 6'b110000) begin n_fail++; $display("FAIL async_reset: got %b%b/%b/%b want 11/00/00", avm_write_n, avm_read_n, arb_grant, req_waitreq_n); end
        n_checks++; if (req_rdata !== 8'h00) begin n_fail++; $display("FAIL async_reset_rdata: got %h want 00", req_rdata); end
        model_rdata = 8'h00;
        step();
        rst = 1'b0;
        slave_stall = 0; avm_readdata = 8'h5C; model_rdata = 8'h5C;
        sb.push_back('{0, 1'b0, 4'h4, 8'h00, 8'h5C, 2});
        sb.push_back('{1, 1'b1, 4'h6, 8'h66, 8'h5C, 3});
        for (int k = 0; k < 2; k++) begin
            wait_ack(10);
            if (k == 0) req_read_n[0] = 1'b1; else req_write_n[1] = 1'b1;
            e = sb.pop_front();
            n_checks++; if (o_ack !== 2'(1 << e.req)) begin n_fail++; $display("FAIL post_reset_order[%0d]: got %b want req %0d", k, o_ack, e.req); end
            n_checks++; if (o_cyc !== e.lat || o_rdata !== e.rdata) begin n_fail++; $display("FAIL post_reset_txn[%0d]: lat %0d rdata %h want %0d %h", k, o_cyc, o_rdata, e.lat, e.rdata); end
        end
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        slave_stall = -1; avm_readdata = 8'hAA;
        req_addr[7:4] = 4'h7; req_read_n[1] = 1'b0;
        model_rdata = 8'hEE;
        sb.push_back('{1, 1'b0, 4'h7, 8'h00, 8'hEE, 17});
        wait_ack(40);
        req_read_n[1] = 1'b1;
        e = sb.pop_front();
        n_checks++; if (o_ack !== 2'(1 << e.req)) begin n_fail++; $display("FAIL to_ack: got %b want req %0d", o_ack, e.req); end
        n_checks++; if (o_cyc !== e.lat || o_strobe !== 16) begin n_fail++; $display("FAIL to_latency: got %0d/%0d want %0d/16", o_cyc, o_strobe, e.lat); end
        n_checks++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL to_rdata: got %h want %h", o_rdata, e.rdata); end
        n_checks++; if (o_err !== 1 || o_err_at_ack !== 1'b1) begin n_fail++; $display("FAIL to_error_pulse: got %0d at_ack %b want 1/1", o_err, o_err_at_ack); end
        step();
        n_checks++; if (arb_error !== 1'b0) begin n_fail++; $display("FAIL to_error_clear: got %b want 0", arb_error); end
    endtask
`else
    task automatic test_timeout();
        slave_stall = -1; avm_readdata = 8'hAA;
        req_addr[7:4] = 4'h7; req_read_n[1] = 1'b0;
        wait_ack(25);
        n_checks++; if (o_ack !== 2'b00 || o_strobe !== 25 || o_stable !== 1'b1) begin n_fail++; $display("FAIL no_to_wait: ack %b strobe %0d stable %b want 00/25/1", o_ack, o_strobe, o_stable); end
        n_checks++; if (o_err !== 0) begin n_fail++; $display("FAIL no_to_error: got %0d want 0", o_err); end
        slave_stall = 0; model_rdata = 8'hAA;
        sb.push_back('{1, 1'b0, 4'h7, 8'h00, 8'hAA, 2});
        wait_ack(10);
        req_read_n[1] = 1'b1;
        e = sb.pop_front();
        n_checks++; if (o_ack !== 2'(1 << e.req) || o_cyc !== e.lat) begin n_fail++; $display("FAIL no_to_ack: got %b/%0d want req %0d/%0d", o_ack, o_cyc, e.req, e.lat); end
        n_checks++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL no_to_rdata: got %h want %h", o_rdata, e.rdata); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_stall();
        test_round_robin();
        test_write_and_read();
        test_reset_mid_issue();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
